// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM type and dequantize helper for the multiplier scheduler
package mult_pkg;

  localparam int BITS_DEFAULT = 10;
  localparam int PROD_MAX_W   = 128;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Negative products get a bias of 2**bits-1 so the arithmetic shift rounds toward zero.
  function automatic logic signed [PROD_MAX_W-1:0] dequant(
    input logic signed [PROD_MAX_W-1:0] p,
    input int unsigned                  bits
  );
    logic signed [PROD_MAX_W-1:0] bias;
    bias = '0;
    if (p < 0) bias = (PROD_MAX_W'(1) << bits) - PROD_MAX_W'(1);
    return (p + bias) >>> bits;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request at or after the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [TAG_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  int               j;
  logic [TAG_W-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    j         = 0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = TAG_W'(j);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - one fixed-point multiplier time-shared round-robin across channels
module mult_share_sched
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = BITS_DEFAULT,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  output logic                          idle,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] a_dout,
  input  logic [NUM_REQ-1:0]            a_empty,
  output logic [NUM_REQ-1:0]            a_rd_en,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] b_dout,
  input  logic [NUM_REQ-1:0]            b_empty,
  output logic [NUM_REQ-1:0]            b_rd_en,
  output logic [NUM_REQ*DATA_WIDTH-1:0] out_din,
  input  logic [NUM_REQ-1:0]            out_full,
  output logic [NUM_REQ-1:0]            out_wr_en
);

  localparam int TAG_W = $clog2(NUM_REQ);

  state_t                         state_q, state_d;
  logic [TAG_W-1:0]               ptr_q, ptr_d;
  logic                           s1_valid_q;
  logic [TAG_W-1:0]               s1_tag_q;
  logic signed [DATA_WIDTH-1:0]   s1_a_q, s1_b_q;
  logic                           s2_valid_q;
  logic [TAG_W-1:0]               s2_tag_q;
  logic signed [2*DATA_WIDTH-1:0] s2_prod_q;

  logic [NUM_REQ-1:0]    req, gnt;
  logic [TAG_W-1:0]      gnt_idx;
  logic                  gnt_valid;
  logic                  issue_ok;
  logic [DATA_WIDTH-1:0] a_sel, b_sel, deq;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN:   if (!enable) state_d = S_DRAIN;
      S_DRAIN: begin
        if (enable) state_d = S_RUN;
        else if (!s1_valid_q && !s2_valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    idle     = (state_q == S_IDLE) && !s1_valid_q && !s2_valid_q;
    issue_ok = (state_q == S_RUN) && enable;
  end

  // A channel with an op in either stage is excluded, so its result FIFO cannot fill before write-back.
  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req[k] = issue_ok && !a_empty[k] && !b_empty[k] && !out_full[k]
             && !(s1_valid_q && (s1_tag_q == TAG_W'(k)))
             && !(s2_valid_q && (s2_tag_q == TAG_W'(k)));
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    a_rd_en = gnt;
    b_rd_en = gnt;
    ptr_d   = ptr_q;
    if (gnt_valid) ptr_d = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        a_sel = a_dout[k*DATA_WIDTH +: DATA_WIDTH];
        b_sel = b_dout[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign deq = DATA_WIDTH'(dequant(PROD_MAX_W'(s2_prod_q), BITS));

  always_comb begin
    out_wr_en = '0;
    out_din   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      out_wr_en[k] = s2_valid_q && (s2_tag_q == TAG_W'(k));
      if (out_wr_en[k]) out_din[k*DATA_WIDTH +: DATA_WIDTH] = deq;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_prod_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      s1_valid_q <= gnt_valid;
      if (gnt_valid) begin
        s1_tag_q <= gnt_idx;
        s1_a_q   <= a_sel;
        s1_b_q   <= b_sel;
      end
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_tag_q;
      s2_prod_q  <= (2*DATA_WIDTH)'(s1_a_q) * (2*DATA_WIDTH)'(s1_b_q);
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - scenario bench with FIFO models and a product/round-toward-zero reference
module tb_mult_share_sched;

  localparam int DW     = 32;
  localparam int BITS   = 10;
  localparam int NR     = 2;
  localparam int ODEPTH = 2;
  localparam int FDEPTH = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           idle;
  logic [NR*DW-1:0] a_dout = '0, b_dout = '0, out_din;
  logic [NR-1:0]  a_empty = '1, b_empty = '1, out_full = '0;
  logic [NR-1:0]  a_rd_en, b_rd_en, out_wr_en;

  mult_share_sched #(.DATA_WIDTH(DW), .BITS(BITS), .NUM_REQ(NR)) dut (
    .clock(clock), .reset(reset), .enable(enable), .idle(idle),
    .a_dout(a_dout), .a_empty(a_empty), .a_rd_en(a_rd_en),
    .b_dout(b_dout), .b_empty(b_empty), .b_rd_en(b_rd_en),
    .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc; int ch; logic ra; logic rb;
    logic [DW-1:0] a; logic [DW-1:0] b; logic ae; logic be; logic full;
  } pop_t;
  typedef struct { int cyc; int ch; logic [DW-1:0] d; int cnt; } wr_t;

  logic [DW-1:0] fa [NR][FDEPTH];
  logic [DW-1:0] fb [NR][FDEPTH];
  int fa_wr[NR], fa_rd[NR], fb_wr[NR], fb_rd[NR], ocnt[NR];
  bit full_hold[NR];
  bit drain_rand;
  pop_t pops[$];
  wr_t  wrs[$];
  bit   idle_hist[$];
  int   cyc, checks, failures;

  // Reference: exact product, integer division truncates toward zero, keep low DW bits.
  function automatic logic [DW-1:0] dq(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p, q;
    p = longint'($signed(a)) * longint'($signed(b));
    q = p / (longint'(1) << BITS);
    return q[DW-1:0];
  endfunction

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      a_empty[k] = (fa_rd[k] == fa_wr[k]);
      b_empty[k] = (fb_rd[k] == fb_wr[k]);
      a_dout[k*DW +: DW] = a_empty[k] ? '0 : fa[k][fa_rd[k]];
      b_dout[k*DW +: DW] = b_empty[k] ? '0 : fb[k][fb_rd[k]];
      out_full[k] = full_hold[k] || (ocnt[k] >= ODEPTH);
    end
  endtask

  task automatic push(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    fa[k][fa_wr[k]] = a; fa_wr[k]++;
    fb[k][fb_wr[k]] = b; fb_wr[k]++;
    drive();
  endtask

  // Sample at the falling edge, then advance FIFO models just after the rising edge.
  task automatic cycle();
    logic [NR-1:0] ra, rb, wr;
    pop_t p;
    wr_t  w;
    @(negedge clock);
    ra = a_rd_en; rb = b_rd_en; wr = out_wr_en;
    idle_hist.push_back(idle);
    for (int k = 0; k < NR; k++) begin
      if (ra[k] || rb[k]) begin
        p.cyc = cyc; p.ch = k; p.ra = ra[k]; p.rb = rb[k];
        p.a = a_dout[k*DW +: DW]; p.b = b_dout[k*DW +: DW];
        p.ae = a_empty[k]; p.be = b_empty[k]; p.full = out_full[k];
        pops.push_back(p);
      end
      if (wr[k]) begin
        w.cyc = cyc; w.ch = k; w.d = out_din[k*DW +: DW]; w.cnt = ocnt[k];
        wrs.push_back(w);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int k = 0; k < NR; k++) begin
      if (ra[k] && fa_rd[k] < fa_wr[k]) fa_rd[k]++;
      if (rb[k] && fb_rd[k] < fb_wr[k]) fb_rd[k]++;
      if (wr[k]) ocnt[k]++;
      if (!drain_rand) ocnt[k] = 0;
      else if (ocnt[k] > 0 && $urandom_range(0, 2) == 0) ocnt[k]--;
    end
    drive();
  endtask

  task automatic clear_models();
    for (int k = 0; k < NR; k++) begin
      fa_wr[k] = 0; fa_rd[k] = 0; fb_wr[k] = 0; fb_rd[k] = 0; ocnt[k] = 0; full_hold[k] = 0;
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; drain_rand = 0;
    clear_models();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    pops.delete(); wrs.delete(); idle_hist.delete(); cyc = 0;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (wrs.size() < n && b < budget) begin cycle(); b++; end
    ok = (wrs.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    clear_models();
    push(0, 32'h400, 32'h600); push(1, 32'h100, 32'h200);
    repeat (3) @(negedge clock);
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %0b want 1", idle); end
    checks++; if (a_rd_en !== '0 || b_rd_en !== '0) begin failures++; $display("FAIL reset_rd_en: got a=%b b=%b want 0", a_rd_en, b_rd_en); end
    checks++; if (out_wr_en !== '0) begin failures++; $display("FAIL reset_wr_en: got %b want 0", out_wr_en); end
    checks++; if (out_din !== '0) begin failures++; $display("FAIL reset_out_din: got %h want 0", out_din); end
    @(posedge clock); #1; reset = 1'b0; enable = 1'b0;
    @(negedge clock);
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL post_reset_idle: got %0b want 1", idle); end
    checks++; if (a_rd_en !== '0) begin failures++; $display("FAIL post_reset_rd_en: got %b want 0", a_rd_en); end
  endtask

  task automatic test_single_op();
    bit ok;
    do_reset();
    push(0, 32'h400, 32'h600);
    enable = 1'b1;
    wait_writes(1, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: got %0d writes want 1", wrs.size()); end
    checks++; if (pops.size() != 1) begin failures++; $display("FAIL single_pop_count: got %0d want 1", pops.size()); end
    if (pops.size() >= 1) begin
      checks++; if (pops[0].cyc != 1 || pops[0].ch != 0) begin failures++; $display("FAIL single_grant: got cyc %0d ch %0d want cyc 1 ch 0", pops[0].cyc, pops[0].ch); end
      checks++; if (!(pops[0].ra && pops[0].rb)) begin failures++; $display("FAIL single_pop_pair: got a=%0b b=%0b want 1 1", pops[0].ra, pops[0].rb); end
      if (ok) begin
        checks++; if (wrs[0].cyc != pops[0].cyc + 2) begin failures++; $display("FAIL single_latency: got cyc %0d want %0d", wrs[0].cyc, pops[0].cyc + 2); end
      end
    end
    if (ok) begin
      checks++; if (wrs[0].ch != 0 || wrs[0].d !== 32'h600) begin failures++; $display("FAIL single_result: got ch %0d %h want ch 0 00000600", wrs[0].ch, wrs[0].d); end
    end
  endtask

  task automatic test_rounding();
    bit ok;
    logic [DW-1:0] exp_v [NR][3];
    int n[NR];
    exp_v[0][0] = 32'h0; exp_v[0][1] = 32'hFFFFF400; exp_v[0][2] = 32'h0;
    exp_v[1][0] = 32'h0; exp_v[1][1] = 32'hFFFFFFFF; exp_v[1][2] = dq(32'h7FFFFFFF, 32'h7FFFFFFF);
    do_reset();
    push(0, 32'hFFFFFFFD, 32'h1); push(0, 32'hFFFFF800, 32'h600);
    push(1, 32'h3, 32'h1); push(1, 32'hFFFFFBFF, 32'h1); push(1, 32'h7FFFFFFF, 32'h7FFFFFFF);
    enable = 1'b1;
    wait_writes(5, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL round_timeout: got %0d writes want 5", wrs.size()); end
    n[0] = 0; n[1] = 0;
    foreach (wrs[i]) begin
      if (n[wrs[i].ch] < 3) begin
        checks++;
        if (wrs[i].d !== exp_v[wrs[i].ch][n[wrs[i].ch]]) begin
          failures++; $display("FAIL round_value ch%0d #%0d: got %h want %h", wrs[i].ch, n[wrs[i].ch], wrs[i].d, exp_v[wrs[i].ch][n[wrs[i].ch]]);
        end
      end
      n[wrs[i].ch]++;
    end
    checks++; if (n[0] != 2 || n[1] != 3) begin failures++; $display("FAIL round_counts: got %0d/%0d want 2/3", n[0], n[1]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int ch;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push(0, $urandom, $urandom);
      push(1, $urandom, $urandom);
    end
    enable = 1'b1;
    wait_writes(12, 100, ok);
    checks++; if (!ok || pops.size() != 12) begin failures++; $display("FAIL b2b_counts: got %0d writes %0d pops want 12 12", wrs.size(), pops.size()); end
    for (int i = 0; i < 12 && i < pops.size() && i < wrs.size(); i++) begin
      ch = i % 2;
      checks++; if (pops[i].ch != ch) begin failures++; $display("FAIL b2b_grant #%0d: got ch %0d want %0d", i, pops[i].ch, ch); end
      checks++; if (wrs[i].ch != ch || wrs[i].d !== dq(fa[ch][i/2], fb[ch][i/2])) begin
        failures++; $display("FAIL b2b_write #%0d: got ch %0d %h want ch %0d %h", i, wrs[i].ch, wrs[i].d, ch, dq(fa[ch][i/2], fb[ch][i/2]));
      end
      checks++; if (wrs[i].cyc != pops[i].cyc + 2) begin failures++; $display("FAIL b2b_latency #%0d: got %0d want %0d", i, wrs[i].cyc, pops[i].cyc + 2); end
    end
  endtask

  task automatic test_full_block();
    bit ok;
    int p1, p0, w0, w1;
    do_reset();
    full_hold[1] = 1'b1;
    push(1, 32'h800, 32'h800); push(1, 32'hFFFFFC00, 32'h1400);
    push(0, 32'h200, 32'h200); push(0, 32'h12345, 32'hFFFFFF00);
    enable = 1'b1;
    repeat (15) cycle();
    p0 = 0; p1 = 0; w0 = 0;
    foreach (pops[i]) if (pops[i].ch == 1) p1++; else p0++;
    foreach (wrs[i]) begin
      if (wrs[i].ch == 0) begin
        if (w0 < 2) begin
          checks++; if (wrs[i].d !== dq(fa[0][w0], fb[0][w0])) begin failures++; $display("FAIL full_ch0_value #%0d: got %h want %h", w0, wrs[i].d, dq(fa[0][w0], fb[0][w0])); end
        end
        w0++;
      end
    end
    checks++; if (p1 != 0) begin failures++; $display("FAIL full_ch1_popped: got %0d pops want 0", p1); end
    checks++; if (p0 != 2 || w0 != 2) begin failures++; $display("FAIL full_ch0_progress: got %0d pops %0d writes want 2 2", p0, w0); end
    full_hold[1] = 1'b0;
    drive();
    wait_writes(4, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_release_timeout: got %0d writes want 4", wrs.size()); end
    w1 = 0;
    foreach (wrs[i]) begin
      if (wrs[i].ch == 1) begin
        if (w1 < 2) begin
          checks++; if (wrs[i].d !== dq(fa[1][w1], fb[1][w1])) begin failures++; $display("FAIL full_ch1_value #%0d: got %h want %h", w1, wrs[i].d, dq(fa[1][w1], fb[1][w1])); end
        end
        w1++;
      end
    end
    checks++; if (w1 != 2) begin failures++; $display("FAIL full_ch1_writes: got %0d want 2", w1); end
  endtask

  task automatic test_drain();
    int b, n;
    do_reset();
    push(0, 32'hC00, 32'h400); push(0, 32'h400, 32'h400);
    enable = 1'b1;
    b = 0;
    while (pops.size() == 0 && b < 20) begin cycle(); b++; end
    checks++; if (pops.size() == 0) begin failures++; $display("FAIL drain_no_grant: got 0 pops want 1"); end
    if (pops.size() > 0) begin
      n = pops[0].cyc;
      enable = 1'b0;
      repeat (4) cycle();
      checks++; if (pops.size() != 1) begin failures++; $display("FAIL drain_new_pop: got %0d pops want 1", pops.size()); end
      checks++; if (wrs.size() != 1) begin failures++; $display("FAIL drain_writes: got %0d want 1", wrs.size()); end
      if (wrs.size() >= 1) begin
        checks++; if (wrs[0].cyc != n + 2 || wrs[0].d !== 32'hC00) begin failures++; $display("FAIL drain_result: got cyc %0d %h want cyc %0d 00000c00", wrs[0].cyc, wrs[0].d, n + 2); end
      end
      if (idle_hist.size() > n + 4) begin
        checks++; if (idle_hist[n+2] !== 1'b0) begin failures++; $display("FAIL drain_idle_early: got 1 want 0"); end
        checks++; if (idle_hist[n+4] !== 1'b1) begin failures++; $display("FAIL drain_idle_late: got 0 want 1"); end
      end
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    int b;
    do_reset();
    push(1, 32'h400, 32'h400);
    enable = 1'b1;
    b = 0;
    while (pops.size() == 0 && b < 20) begin cycle(); b++; end
    push(0, 32'h800, 32'h800);
    cycle();
    checks++; if (pops.size() != 2 || pops[pops.size()-1].ch != 0) begin failures++; $display("FAIL midop_setup: got %0d pops want 2 ending ch0", pops.size()); end
    reset = 1'b1;
    clear_models();
    repeat (3) cycle();
    checks++; if (wrs.size() != 0) begin failures++; $display("FAIL midop_write_in_reset: got %0d writes want 0", wrs.size()); end
    checks++; if (idle_hist[idle_hist.size()-1] !== 1'b1) begin failures++; $display("FAIL midop_idle_in_reset: got 0 want 1"); end
    reset = 1'b0; enable = 1'b0;
    pops.delete(); wrs.delete(); idle_hist.delete(); cyc = 0;
    repeat (3) cycle();
    checks++; if (wrs.size() != 0 || idle_hist[2] !== 1'b1) begin failures++; $display("FAIL midop_after_reset: got %0d writes idle %0b want 0 1", wrs.size(), idle_hist[2]); end
    push(0, 32'h1400, 32'h400); push(1, 32'h2800, 32'h400);
    enable = 1'b1;
    wait_writes(2, 20, ok);
    checks++; if (!ok || pops.size() < 1) begin failures++; $display("FAIL midop_restart: got %0d writes want 2", wrs.size()); end
    else begin
      checks++; if (pops[0].ch != 0) begin failures++; $display("FAIL midop_pointer: got first grant ch %0d want 0", pops[0].ch); end
      checks++; if (wrs[0].ch != 0 || wrs[0].d !== 32'h1400) begin failures++; $display("FAIL midop_result: got ch %0d %h want ch 0 00001400", wrs[0].ch, wrs[0].d); end
    end
  endtask

  task automatic test_random();
    int na[NR], nb[NR], np[NR], nw[NR], lastp[NR];
    int pcyc [NR][FDEPTH];
    int b, total, ch, idx;
    total = 30;
    do_reset();
    drain_rand = 1'b1;
    for (int k = 0; k < NR; k++) begin na[k] = 0; nb[k] = 0; np[k] = 0; nw[k] = 0; lastp[k] = -10; end
    enable = 1'b1;
    b = 0;
    while (wrs.size() < NR * total && b < 3000) begin
      for (int k = 0; k < NR; k++) begin
        if (na[k] < total && $urandom_range(0, 3) == 0) begin fa[k][fa_wr[k]] = $urandom; fa_wr[k]++; na[k]++; end
        if (nb[k] < total && $urandom_range(0, 3) == 0) begin fb[k][fb_wr[k]] = $urandom; fb_wr[k]++; nb[k]++; end
      end
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      drive();
      cycle();
      b++;
    end
    checks++; if (wrs.size() != NR * total) begin failures++; $display("FAIL rand_done: got %0d writes want %0d", wrs.size(), NR * total); end
    foreach (pops[i]) begin
      ch = pops[i].ch;
      checks++; if (pops[i].ra !== pops[i].rb) begin failures++; $display("FAIL rand_pop_pair cyc %0d: got a=%0b b=%0b want equal", pops[i].cyc, pops[i].ra, pops[i].rb); end
      checks++; if (pops[i].ae || pops[i].be || pops[i].full) begin failures++; $display("FAIL rand_pop_ineligible cyc %0d ch%0d: got ae=%0b be=%0b full=%0b want 0", pops[i].cyc, ch, pops[i].ae, pops[i].be, pops[i].full); end
      if (i > 0) begin
        checks++; if (pops[i].cyc == pops[i-1].cyc) begin failures++; $display("FAIL rand_two_grants cyc %0d: got 2 want 1", pops[i].cyc); end
      end
      checks++; if (pops[i].cyc - lastp[ch] < 3) begin failures++; $display("FAIL rand_inflight ch%0d: got gap %0d want >=3", ch, pops[i].cyc - lastp[ch]); end
      lastp[ch] = pops[i].cyc;
      if (np[ch] < FDEPTH) pcyc[ch][np[ch]] = pops[i].cyc;
      np[ch]++;
    end
    foreach (wrs[i]) begin
      ch = wrs[i].ch;
      idx = nw[ch];
      checks++; if (wrs[i].cnt >= ODEPTH) begin failures++; $display("FAIL rand_overflow ch%0d: got count %0d want <%0d", ch, wrs[i].cnt, ODEPTH); end
      if (idx < total) begin
        checks++; if (wrs[i].d !== dq(fa[ch][idx], fb[ch][idx])) begin failures++; $display("FAIL rand_value ch%0d #%0d: got %h want %h", ch, idx, wrs[i].d, dq(fa[ch][idx], fb[ch][idx])); end
      end
      if (idx < np[ch] && idx < FDEPTH) begin
        checks++; if (wrs[i].cyc != pcyc[ch][idx] + 2) begin failures++; $display("FAIL rand_latency ch%0d #%0d: got %0d want %0d", ch, idx, wrs[i].cyc, pcyc[ch][idx] + 2); end
      end
      nw[ch]++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_op();
    test_rounding();
    test_back_to_back();
    test_full_block();
    test_drain();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
